// File: rtl/inv_round_engine.sv
// Iterative 16-round Feistel engine: a single combinational round is applied once per
// clock to a 64-bit state register, walking the stored key set forward or backward.

module des_round (
  input  logic [63:0] blk_i,
  input  logic [47:0] key_i,
  output logic [63:0] blk_o
);
  // Entry n of each box sits at bits [255-4n -: 4]; n = {b5, b0, b4..b1}.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  logic [31:0] l, r, s, p;
  logic [47:0] e, x;

  assign l = blk_i[63:32];
  assign r = blk_i[31:0];

  assign e = {r[0], r[31:27], r[28:23], r[24:19], r[20:15],
              r[16:11], r[12:7], r[8:3], r[4:0], r[31]};
  assign x = e ^ key_i;

  for (genvar g = 0; g < 8; g++) begin : g_sbox
    logic [5:0] six;
    assign six = x[47-6*g -: 6];
    assign s[31-4*g -: 4] = SBOX[g][{~{six[5], six[0], six[4:1]}, 2'b11} -: 4];
  end

  assign p = {s[16], s[25], s[12], s[11], s[3],  s[20], s[4],  s[15],
              s[31], s[17], s[9],  s[6],  s[27], s[14], s[1],  s[22],
              s[30], s[24], s[8],  s[18], s[0],  s[5],  s[29], s[23],
              s[13], s[19], s[2],  s[26], s[10], s[21], s[28], s[7]};

  assign blk_o = {r, l ^ p};
endmodule

module inv_round_engine #(
  parameter int DECRYPT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_block,
  input  logic [767:0] round_keys,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_block,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e       state_q;
  logic [63:0]  blk_q, blk_d;
  logic [767:0] keys_q;
  logic [3:0]   cnt_q;
  logic         in_ready_q, out_valid_q, busy_q;
  logic [63:0]  out_block_q;
  logic [47:0]  rkey [16];
  logic [3:0]   kidx;
  logic [47:0]  key_sel;

  for (genvar k = 0; k < 16; k++) begin : g_key
    assign rkey[k] = keys_q[767-48*k -: 48];
  end

  // Decrypt walks key 16..1, i.e. index 15-cnt, which is ~cnt in 4 bits.
  assign kidx    = (DECRYPT != 0) ? ~cnt_q : cnt_q;
  assign key_sel = rkey[kidx];

  des_round u_round (
    .blk_i (blk_q),
    .key_i (key_sel),
    .blk_o (blk_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      blk_q       <= '0;
      keys_q      <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_block_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            blk_q      <= in_block;
            keys_q     <= round_keys;
            cnt_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          blk_q <= blk_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_block_q <= {blk_d[31:0], blk_d[63:32]};
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_block_q <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
          out_block_q <= '0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_block = out_block_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_inv_round_engine.sv
// Scoreboard bench: a decrypt engine (index 0) and an encrypt engine (index 1) checked
// against a table-driven cipher model with key schedule and initial permutation.

module tb_inv_round_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         iv  [2];
  logic         ir  [2];
  logic [63:0]  ib  [2];
  logic [767:0] rk  [2];
  logic         ov  [2];
  logic         orr [2];
  logic [63:0]  ob  [2];
  logic         bsy [2];

  inv_round_engine #(.DECRYPT(1)) u_dec (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_block(ib[0]),
    .round_keys(rk[0]), .out_valid(ov[0]), .out_ready(orr[0]), .out_block(ob[0]),
    .busy(bsy[0]));

  inv_round_engine #(.DECRYPT(0)) u_enc (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_block(ib[1]),
    .round_keys(rk[1]), .out_valid(ov[1]), .out_ready(orr[1]), .out_block(ob[1]),
    .busy(bsy[1]));

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                              16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29,
                              28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                                16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                                44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SHIFT_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam logic [255:0] SB [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT  = 64'h85E813540F0AB405;
  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;

  // ---------------- reference model ----------------
  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s, p;
    int v, row, col;
    for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
    e = e ^ k;
    for (int j = 0; j < 8; j++) begin
      v   = int'(e[47-6*j -: 6]);
      row = ((v >> 4) & 2) | (v & 1);
      col = (v >> 1) & 15;
      s[31-4*j -: 4] = SB[j][255-4*(row*16+col) -: 4];
    end
    for (int i = 0; i < 32; i++) p[31-i] = s[32-P_T[i]];
    return p;
  endfunction

  // Sixteen rounds on {L,R}, halves swapped at the end; dec walks keys 16..1.
  function automatic logic [63:0] stack(input logic [63:0] x, input logic [767:0] keys,
                                        input bit dec);
    logic [31:0] l, r, t;
    int ki;
    l = x[63:32];
    r = x[31:0];
    for (int i = 0; i < 16; i++) begin
      ki = dec ? 15 - i : i;
      t  = r;
      r  = l ^ feistel(r, keys[767-48*ki -: 48]);
      l  = t;
    end
    return {r, l};
  endfunction

  function automatic logic [767:0] sched(input logic [63:0] key);
    logic [55:0]  cd;
    logic [27:0]  c, d;
    logic [767:0] ks;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SHIFT_T[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) ks[767-48*r-i] = cd[56-PC2_T[i]];
    end
    return ks;
  endfunction

  function automatic logic [767:0] rand_keys();
    logic [767:0] k;
    for (int w = 0; w < 24; w++) k[32*w +: 32] = $urandom;
    return k;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [63:0] data;
    int          acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic seen [2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sb_size(input int idx);
    return (idx == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t sb_front(input int idx);
    return (idx == 0) ? q0[0] : q1[0];
  endfunction

  function automatic void sb_push(input int idx, input exp_t e);
    if (idx == 0) q0.push_back(e); else q1.push_back(e);
  endfunction

  function automatic void sb_pop(input int idx);
    if (idx == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endfunction

  function automatic void sb_clear(input int idx);
    if (idx == 0) q0.delete(); else q1.delete();
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s[%0d] @cyc %0d: got %h want %h", name, idx, cyc, act, expv);
    end
  endtask

  task automatic timeout(input string name, input int idx);
    total++;
    bad++;
    $display("FAIL %s[%0d] @cyc %0d: got timeout want event", name, idx, cyc);
  endtask

  task automatic mon_step(input int idx);
    exp_t e;
    if (ov[idx]) begin
      if (sb_size(idx) == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out[%0d] @cyc %0d: got out_valid=1 block %h want none",
                 idx, cyc, ob[idx]);
      end else begin
        e = sb_front(idx);
        if (!seen[idx]) begin
          chk("latency", idx, 64'(cyc - e.acc), 64'd16);
          seen[idx] = 1'b1;
        end
        chk("out_block", idx, ob[idx], e.data);
        chk("in_ready_done", idx, 64'(ir[idx]), 64'd0);
        if (orr[idx]) begin
          sb_pop(idx);
          seen[idx] = 1'b0;
        end
      end
    end else begin
      chk("out_block_idle", idx, ob[idx], 64'd0);
    end
  endtask

  initial begin
    seen[0] = 1'b0;
    seen[1] = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        seen[0] = 1'b0;
        seen[1] = 1'b0;
      end else begin
        mon_step(0);
        mon_step(1);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called at a falling edge; keeps in_valid high with junk for `junk` clocks after accept.
  task automatic issue(input int idx, input logic [63:0] blk, input logic [767:0] keys,
                       input logic [63:0] expv, input int junk);
    exp_t e;
    int   n;
    n = 0;
    while (!ir[idx] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ir[idx]) begin
      timeout("ready_wait", idx);
      return;
    end
    iv[idx] = 1'b1;
    ib[idx] = blk;
    rk[idx] = keys;
    e.data  = expv;
    e.acc   = cyc + 1;
    sb_push(idx, e);
    @(negedge clk);
    for (int j = 0; j < junk; j++) begin
      ib[idx] = {$urandom, $urandom};
      rk[idx] = rand_keys();
      @(negedge clk);
    end
    iv[idx] = 1'b0;
  endtask

  task automatic wait_idle(input int idx);
    int n;
    n = 0;
    while (sb_size(idx) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb_size(idx) != 0) timeout("drain", idx);
  endtask

  task automatic chk_idle(input string name, input int idx);
    chk({name, "_in_ready"}, idx, 64'(ir[idx]), 64'd1);
    chk({name, "_out_valid"}, idx, 64'(ov[idx]), 64'd0);
    chk({name, "_out_block"}, idx, ob[idx], 64'd0);
    chk({name, "_busy"}, idx, 64'(bsy[idx]), 64'd0);
  endtask

  initial begin
    logic [767:0] ks, k;
    logic [63:0]  x, c;
    int           n;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      iv[i]  = 1'b0;
      orr[i] = 1'b1;
      ib[i]  = '0;
      rk[i]  = '0;
    end
    repeat (3) @(negedge clk);
    chk_idle("reset", 0);
    chk_idle("reset", 1);
    rst = 1'b0;
    ks  = sched(KEY);

    // Known answer both directions, accepted on the first edge after reset.
    fork
      issue(0, ip(CT), ks, ip(PT), 0);
      issue(1, ip(PT), ks, ip(CT), 0);
    join
    chk("busy_run", 0, 64'(bsy[0]), 64'd1);
    chk("in_ready_run", 1, 64'(ir[1]), 64'd0);
    wait_idle(0);
    wait_idle(1);

    // Backpressure: result held for 5 clocks, released one edge after out_ready.
    orr[0] = 1'b0;
    issue(0, ip(CT), ks, ip(PT), 0);
    n = 0;
    while (!ov[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ov[0]) timeout("bp_valid", 0);
    for (int j = 0; j < 5; j++) begin
      chk("bp_out_valid", 0, 64'(ov[0]), 64'd1);
      chk("bp_in_ready", 0, 64'(ir[0]), 64'd0);
      @(negedge clk);
    end
    orr[0] = 1'b1;
    @(negedge clk);
    chk_idle("bp_release", 0);

    // Inputs scrambled (with in_valid high) while the operation runs.
    fork
      issue(0, ip(CT), ks, ip(PT), 12);
      issue(1, ip(PT), ks, ip(CT), 12);
    join
    wait_idle(0);
    wait_idle(1);

    // Reset at cnt=9 aborts; nothing may come out, then a clean operation.
    issue(0, ip(CT), ks, ip(PT), 0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    sb_clear(0);
    @(negedge clk);
    chk_idle("abort", 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    issue(0, ip(CT), ks, ip(PT), 0);
    wait_idle(0);

    // Randomized round trip with random key sets and in_valid held while busy.
    for (int v = 0; v < 1000; v++) begin
      x = {$urandom, $urandom};
      k = rand_keys();
      c = stack(x, k, 1'b0);
      fork
        issue(1, x, k, c, int'($urandom_range(0, 10)));
        issue(0, c, k, x, int'($urandom_range(0, 10)));
      join
    end
    wait_idle(0);
    wait_idle(1);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
